alloc_lsu: RTL
==============

Name: alloc_lsu

Overview:
- Load/store unit directly downstream of the allocator core FSM.
- Accepts one header_data_req_t at a time (LOCK, UNLOCK, LOAD, INSERT, DELETE) and turns it into a sequence of single-word memory transactions on a req/gnt/rvalid port.
- Returns one header_data_rsp_t pulse per completed request.
- Owns the free-list lock protocol (test-and-set on a lock word in memory).

Parameters:
- LOCK_ADDR, 'h0, byte address of the lock word; 0 = free, 1 = held.
- WORD_BYTES, DATA_W/8, byte offset between header fields.
- BACKOFF_CYCLES, 4, idle cycles between failed LOCK attempts; legal range 0..255.
- LOCK_RETRY_MAX, 16, attempt limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_i  in  header_data_req_t  request from core (val, lsu_op, header_data{addr,size,next_addr})
- lsu_ready_o  out  1  unit can accept a request this cycle
- rsp_o  out  header_data_rsp_t  response to core (val, header_data)
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  DATA_W  byte address
- mem_wdata_o  out  DATA_W  write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_W  read data

Behaviour:
- Clock is clk_i; reset is synchronous, active-high, on rst_i (sampled at posedge).
- Reset values:
  - lsu_ready_o=1; rsp_o='0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - State IDLE; backoff counter 0; latched request 0.
- Header layout in memory: size at addr; next_addr at addr+WORD_BYTES. Address addition wraps modulo 2^DATA_W.
- Request acceptance:
  - Accept when req_i.val && lsu_ready_o; latch the whole request that cycle.
  - lsu_ready_o=1 only in IDLE.
  - req_i.val while not ready is ignored, not queued.
- Memory handshake:
  - mem_req_o and address/data/we are held stable until mem_gnt_i.
  - A write completes on gnt.
  - A read completes on the first mem_rvalid_i strictly after its gnt.
  - At most one transaction outstanding.
- States: IDLE, MEM_RD0, WAIT_RD0, MEM_RD1, WAIT_RD1, MEM_WR0, MEM_WR1, LOCK_RD, LOCK_WAIT, LOCK_WR, BACKOFF, RESP.
- Operation sequences:
  - LOAD: read addr (size) -> read addr+WORD_BYTES (next_addr) -> RESP. Response header_data = {addr=req addr, size, next_addr from memory}.
  - INSERT: write size to addr -> write next_addr to addr+WORD_BYTES -> RESP. Response echoes the request header.
  - DELETE: single write of header_data.next_addr to addr+WORD_BYTES (relinks the predecessor) -> RESP. Response echoes the request.
  - LOCK: read LOCK_ADDR.
    - Read returns 0: write 1 to LOCK_ADDR -> RESP.
    - Read returns nonzero: go to BACKOFF for BACKOFF_CYCLES cycles, then re-read (unbounded retries without the feature). BACKOFF_CYCLES=0 re-reads the next cycle.
  - UNLOCK: write 0 to LOCK_ADDR -> RESP. No check of the prior value.
- RESP:
  - rsp_o.val=1 for exactly one cycle, then IDLE with lsu_ready_o=1 on the following cycle.
  - Minimum accept-to-response latency with gnt and rvalid zero-wait: LOAD 5 cycles, INSERT 3, DELETE 2, UNLOCK 2, LOCK-free 4.
  - rsp_o.header_data holds its value until the next response; rsp_o.val is 0 outside RESP.
- Unknown lsu_op: no memory traffic; go directly to RESP with header echoed.
- Reset mid-operation:
  - Abandon the sequence and drop mem_req_o.
  - Any later rvalid for the abandoned read is ignored.
  - A lock acquired before reset stays held in memory; software clears it.
- rvalid arriving while no read is outstanding: ignored.

Optional Feature:
- Macro: ALLOC_LSU_LOCK_TIMEOUT_EN.
- Defined:
  - Adds output port lock_fail_o (1 bit, reset 0).
  - Counts failed LOCK reads. When LOCK_RETRY_MAX reads have all returned nonzero, enter RESP with rsp_o.val=1 and lock_fail_o=1 for that same cycle; no write to LOCK_ADDR.
  - The counter clears on every new accepted request.
- Undefined: port absent; LOCK retries indefinitely.

Test Plan:
- LOAD addr='h10, memory ['h10]=100, ['h18]='h40, zero-wait memory -> reads 'h10 then 'h18; rsp_o.val 5 cycles after accept with {addr='h10, size=100, next_addr='h40}.
- INSERT {addr='h80, size=36, next_addr='h40} -> two writes: 'h80<=36 then 'h88<='h40; single rsp pulse; lsu_ready_o back high the cycle after.
- LOCK with ['h0]=1 for the first 3 reads, then 0 (BACKOFF_CYCLES=4) -> 4 reads spaced by 4 idle cycles, then write 'h0<=1, one rsp pulse. With ALLOC_LSU_LOCK_TIMEOUT_EN and LOCK_RETRY_MAX=2 -> after 2 reads, rsp pulse with lock_fail_o=1 and no write.
- Memory gnt stalled 3 cycles during DELETE {addr='h10, next_addr='h80} -> mem_addr_o='h18 and mem_wdata_o='h80 held stable all 3 cycles; second req_i.val during the op ignored.
- rst_i asserted while in WAIT_RD0 of a LOAD, with late rvalid after reset -> outputs at reset values next cycle; late rvalid produces no rsp; subsequent UNLOCK writes 'h0<=0 and responds normally.

Source files
------------

// File: rtl/alloc_lsu.sv
// alloc_lsu: load/store unit below the allocator core; turns header requests into single-word
// memory transactions. Define ALLOC_LSU_LOCK_TIMEOUT_EN to bound LOCK retries (adds lock_fail_o).

localparam int LSU_DATA_W = 64;

typedef enum logic [2:0] {
  LSU_LOCK   = 3'd0,
  LSU_UNLOCK = 3'd1,
  LSU_LOAD   = 3'd2,
  LSU_INSERT = 3'd3,
  LSU_DELETE = 3'd4
} lsu_op_e;

typedef struct packed {
  logic [LSU_DATA_W-1:0] addr;
  logic [LSU_DATA_W-1:0] size;
  logic [LSU_DATA_W-1:0] next_addr;
} header_data_t;

typedef struct packed {
  logic         val;
  lsu_op_e      lsu_op;
  header_data_t header_data;
} header_data_req_t;

typedef struct packed {
  logic         val;
  header_data_t header_data;
} header_data_rsp_t;

typedef enum logic [3:0] {
  ST_IDLE, ST_MEM_RD0, ST_WAIT_RD0, ST_MEM_RD1, ST_WAIT_RD1, ST_MEM_WR0,
  ST_MEM_WR1, ST_LOCK_RD, ST_LOCK_WAIT, ST_LOCK_WR, ST_BACKOFF, ST_RESP
} alloc_lsu_state_e;

module alloc_lsu #(
  parameter logic [LSU_DATA_W-1:0] LOCK_ADDR      = '0,
  parameter int unsigned           WORD_BYTES     = LSU_DATA_W / 8,
  parameter int unsigned           BACKOFF_CYCLES = 4
`ifdef ALLOC_LSU_LOCK_TIMEOUT_EN
  , parameter int unsigned         LOCK_RETRY_MAX = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  header_data_req_t      req_i,
  output logic                  lsu_ready_o,
  output header_data_rsp_t      rsp_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [LSU_DATA_W-1:0] mem_addr_o,
  output logic [LSU_DATA_W-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [LSU_DATA_W-1:0] mem_rdata_i,
`ifdef ALLOC_LSU_LOCK_TIMEOUT_EN
  output logic                  lock_fail_o,
`endif
  output alloc_lsu_state_e      dbg_state_o
);

  // Handshakes: a request is taken when req_i.val && lsu_ready_o at a clock edge. A memory
  // transaction is offered with mem_req_o and held stable until mem_gnt_i; a read then finishes
  // on the first mem_rvalid_i in a later cycle, while a write finishes on the grant itself.

  localparam logic [7:0] BACKOFF_LOAD = (BACKOFF_CYCLES == 0) ? 8'd0 : 8'(BACKOFF_CYCLES - 1);

  alloc_lsu_state_e      r_state;
  alloc_lsu_state_e      w_state_nxt;
  lsu_op_e               r_op;
  header_data_t          r_hd;
  header_data_t          r_rsp_hd;
  logic [LSU_DATA_W-1:0] r_size;
  logic [7:0]            r_backoff;
  logic [LSU_DATA_W-1:0] w_addr_hi;
  logic                  w_accept;
  logic                  w_lock_busy;
`ifdef ALLOC_LSU_LOCK_TIMEOUT_EN
  logic [15:0]           r_fail_cnt;
  logic                  r_lock_fail;
  logic                  w_fail_hit;
`endif

  always_comb begin
    w_state_nxt = r_state;
    lsu_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    w_addr_hi   = r_hd.addr + LSU_DATA_W'(WORD_BYTES);
    w_accept    = (r_state == ST_IDLE) && req_i.val;
    w_lock_busy = mem_rvalid_i && (mem_rdata_i != '0);
`ifdef ALLOC_LSU_LOCK_TIMEOUT_EN
    w_fail_hit  = (r_fail_cnt + 16'd1) >= 16'(LOCK_RETRY_MAX);
`endif
    rsp_o.val         = (r_state == ST_RESP);
    rsp_o.header_data = r_rsp_hd;
    case (r_state)
      ST_IDLE: begin
        lsu_ready_o = 1'b1;
        if (req_i.val) begin
          case (req_i.lsu_op)
            LSU_LOCK:   w_state_nxt = ST_LOCK_RD;
            LSU_UNLOCK: w_state_nxt = ST_LOCK_WR;
            LSU_LOAD:   w_state_nxt = ST_MEM_RD0;
            LSU_INSERT: w_state_nxt = ST_MEM_WR0;
            LSU_DELETE: w_state_nxt = ST_MEM_WR1;
            default:    w_state_nxt = ST_RESP;
          endcase
        end
      end
      ST_MEM_RD0: begin
        mem_req_o  = 1'b1;
        mem_addr_o = r_hd.addr;
        if (mem_gnt_i) w_state_nxt = ST_WAIT_RD0;
      end
      ST_WAIT_RD0: if (mem_rvalid_i) w_state_nxt = ST_MEM_RD1;
      ST_MEM_RD1: begin
        mem_req_o  = 1'b1;
        mem_addr_o = w_addr_hi;
        if (mem_gnt_i) w_state_nxt = ST_WAIT_RD1;
      end
      ST_WAIT_RD1: if (mem_rvalid_i) w_state_nxt = ST_RESP;
      ST_MEM_WR0: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = r_hd.addr;
        mem_wdata_o = r_hd.size;
        if (mem_gnt_i) w_state_nxt = ST_MEM_WR1;
      end
      ST_MEM_WR1: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = w_addr_hi;
        mem_wdata_o = r_hd.next_addr;
        if (mem_gnt_i) w_state_nxt = ST_RESP;
      end
      ST_LOCK_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = LOCK_ADDR;
        if (mem_gnt_i) w_state_nxt = ST_LOCK_WAIT;
      end
      ST_LOCK_WAIT: begin
        if (mem_rvalid_i && !w_lock_busy) w_state_nxt = ST_LOCK_WR;
`ifdef ALLOC_LSU_LOCK_TIMEOUT_EN
        else if (w_lock_busy && w_fail_hit) w_state_nxt = ST_RESP;
`endif
        else if (w_lock_busy) w_state_nxt = (BACKOFF_CYCLES == 0) ? ST_LOCK_RD : ST_BACKOFF;
      end
      ST_LOCK_WR: begin
        // Shared by LOCK (take: write 1) and UNLOCK (release: write 0).
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = LOCK_ADDR;
        mem_wdata_o = {{(LSU_DATA_W-1){1'b0}}, r_op == LSU_LOCK};
        if (mem_gnt_i) w_state_nxt = ST_RESP;
      end
      ST_BACKOFF: if (r_backoff == 8'd0) w_state_nxt = ST_LOCK_RD;
      ST_RESP:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_op      <= LSU_LOCK;
      r_hd      <= '0;
      r_rsp_hd  <= '0;
      r_size    <= '0;
      r_backoff <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op <= req_i.lsu_op;
        r_hd <= req_i.header_data;
      end
      if (r_state == ST_WAIT_RD0 && mem_rvalid_i) r_size <= mem_rdata_i;
      if (r_state == ST_BACKOFF) r_backoff <= r_backoff - 8'd1;
      else if (w_state_nxt == ST_BACKOFF) r_backoff <= BACKOFF_LOAD;
      // Response header is captured on the way into RESP and then held until the next one.
      if (w_state_nxt == ST_RESP) begin
        if (r_state == ST_IDLE) r_rsp_hd <= req_i.header_data;
        else if (r_state == ST_WAIT_RD1) begin
          r_rsp_hd.addr      <= r_hd.addr;
          r_rsp_hd.size      <= r_size;
          r_rsp_hd.next_addr <= mem_rdata_i;
        end else r_rsp_hd <= r_hd;
      end
    end
  end

`ifdef ALLOC_LSU_LOCK_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fail_cnt  <= '0;
      r_lock_fail <= 1'b0;
    end else if (w_accept) begin
      r_fail_cnt  <= '0;
      r_lock_fail <= 1'b0;
    end else if (r_state == ST_LOCK_WAIT && w_lock_busy) begin
      r_fail_cnt <= r_fail_cnt + 16'd1;
      if (w_fail_hit) r_lock_fail <= 1'b1;
    end
  end

  assign lock_fail_o = (r_state == ST_RESP) && r_lock_fail;
`endif

  assign dbg_state_o = r_state;

endmodule
